// File: rtl/proxy_pkg.sv
// Shared types for the proxy receive path: beat data type and FIFO occupancy classes.
package proxy_pkg;

   localparam int PROXY_DATA_W = 8;

   typedef logic [PROXY_DATA_W-1:0] proxy_data_t;

   typedef enum logic [1:0] {
      OCC_EMPTY,
      OCC_PARTIAL,
      OCC_FULL
   } occ_state_e;

endpackage

// File: rtl/proxy_rx_collector_if.sv
// Proxy beat input plus FWFT valid/ready output of the collector.
// master = proxy stage / consumer side, slave = collector.
interface proxy_rx_collector_if
   import proxy_pkg::*;
#(
   parameter int DATA_W = PROXY_DATA_W
);
   logic [DATA_W-1:0] proxy_data;
   logic              proxy_valid;
   logic [DATA_W-1:0] out_data;
   logic              out_valid;
   logic              out_ready;

   modport master (
      output proxy_data, proxy_valid, out_ready,
      input  out_data, out_valid
   );

   modport slave (
      input  proxy_data, proxy_valid, out_ready,
      output out_data, out_valid
   );
endinterface

// File: rtl/proxy_rx_fifo_mem.sv
// DEPTH x DATA_W storage: one synchronous write port, asynchronous read, no reset.
module proxy_rx_fifo_mem
   import proxy_pkg::*;
#(
   parameter int DATA_W = PROXY_DATA_W,
   parameter int DEPTH  = 4,
   parameter int AW     = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic [AW-1:0]     waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [AW-1:0]     raddr_i,
   output logic [DATA_W-1:0] rdata_o
);
   logic [DATA_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/proxy_rx_collector.sv
// Collects proxy beats into a FWFT FIFO; beats arriving while full are dropped and flagged.
// Optional statistics counters are built only when PROXY_RX_STATS_EN is defined.
module proxy_rx_collector
   import proxy_pkg::*;
#(
   parameter int DATA_W = PROXY_DATA_W,
   parameter int DEPTH  = 4,
   parameter int CNT_W  = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   proxy_rx_collector_if.slave      bus,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic                     overflow,
   input  logic                     clr_overflow,
   output logic [CNT_W-1:0]         beat_cnt,
   output logic [CNT_W-1:0]         drop_cnt
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int OCC_W = PTR_W + 1;
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);
   localparam logic [OCC_W-1:0] OCC_LAST = OCC_W'(DEPTH - 1);

   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [OCC_W-1:0] count_q;
   occ_state_e       occ_q;
   logic             ovf_q;

   logic full, valid, push, pop, drop;

   // Occupancy class is registered, so full/valid come straight off flops.
   assign full  = (occ_q == OCC_FULL);
   assign valid = (occ_q != OCC_EMPTY);
   assign pop   = valid && bus.out_ready;
   assign push  = bus.proxy_valid && (!full || pop);
   assign drop  = bus.proxy_valid && full && !pop;

   proxy_rx_fifo_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .AW     (PTR_W)
   ) u_mem (
      .clk     (clk),
      .we_i    (push),
      .waddr_i (wr_ptr_q),
      .wdata_i (bus.proxy_data),
      .raddr_i (rd_ptr_q),
      .rdata_o (bus.out_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
         if (push && !pop)      count_q <= count_q + OCC_ONE;
         else if (pop && !push) count_q <= count_q - OCC_ONE;
         // A drop in the same cycle as a clear keeps the flag set.
         if (drop)              ovf_q <= 1'b1;
         else if (clr_overflow) ovf_q <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         occ_q <= OCC_EMPTY;
      end else begin
         case (occ_q)
            OCC_EMPTY:   if (push) occ_q <= OCC_PARTIAL;
            OCC_PARTIAL: begin
               if (push && !pop && count_q == OCC_LAST)     occ_q <= OCC_FULL;
               else if (pop && !push && count_q == OCC_ONE) occ_q <= OCC_EMPTY;
            end
            OCC_FULL:    if (pop && !push) occ_q <= OCC_PARTIAL;
            default:     occ_q <= OCC_EMPTY;
         endcase
      end
   end

   assign bus.out_valid = valid;
   assign fifo_count    = count_q;
   assign overflow      = ovf_q;

`ifdef PROXY_RX_STATS_EN
   logic [CNT_W-1:0] beat_cnt_q, drop_cnt_q;

   // Both counters saturate at all-ones and only reset clears them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beat_cnt_q <= '0;
         drop_cnt_q <= '0;
      end else begin
         if (push && beat_cnt_q != '1) beat_cnt_q <= beat_cnt_q + CNT_W'(1);
         if (drop && drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + CNT_W'(1);
      end
   end

   assign beat_cnt = beat_cnt_q;
   assign drop_cnt = drop_cnt_q;
`else
   assign beat_cnt = '0;
   assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_proxy_rx_collector.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based model.
module tb_proxy_rx_collector;
   import proxy_pkg::*;

   localparam int DEPTH = 4;
   localparam int CNT_W = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic clr_overflow = 1'b0;
   logic [$clog2(DEPTH):0] fifo_count;
   logic overflow;
   logic [CNT_W-1:0] beat_cnt, drop_cnt;

   proxy_rx_collector_if #(.DATA_W(PROXY_DATA_W)) bus ();

   proxy_rx_collector #(
      .DATA_W (PROXY_DATA_W),
      .DEPTH  (DEPTH),
      .CNT_W  (CNT_W)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .bus          (bus.slave),
      .fifo_count   (fifo_count),
      .overflow     (overflow),
      .clr_overflow (clr_overflow),
      .beat_cnt     (beat_cnt),
      .drop_cnt     (drop_cnt)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   // reference model: FIFO contents as a queue, plus flag and totals
   proxy_data_t mq[$];
   logic        m_ovf;
   int          m_beats, m_drops;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [31:0] stat_exp(input int n);
`ifdef PROXY_RX_STATS_EN
      return (n > 65535) ? 32'd65535 : 32'(n);
`else
      return (n < 0) ? 32'd1 : 32'd0;
`endif
   endfunction

   task automatic model_clear();
      mq.delete();
      m_ovf   = 1'b0;
      m_beats = 0;
      m_drops = 0;
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".valid"}, 32'(bus.out_valid), 32'(mq.size() != 0));
      chk({tag, ".count"}, 32'(fifo_count), 32'(mq.size()));
      chk({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
      if (mq.size() != 0) chk({tag, ".data"}, 32'(bus.out_data), 32'(mq[0]));
      chk({tag, ".beats"}, 32'(beat_cnt), stat_exp(m_beats));
      chk({tag, ".drops"}, 32'(drop_cnt), stat_exp(m_drops));
   endtask

   // Drive one cycle's inputs (called just after a falling edge), advance the model, check at the next falling edge.
   task automatic cyc(input string tag, input logic v, input proxy_data_t d, input logic rdy, input logic clr);
      bit pop, push, drop;
      bus.proxy_valid = v;
      bus.proxy_data  = d;
      bus.out_ready   = rdy;
      clr_overflow    = clr;
      pop  = (mq.size() != 0) && rdy;
      push = v && ((mq.size() < DEPTH) || pop);
      drop = v && !push;
      @(posedge clk);
      if (pop)  void'(mq.pop_front());
      if (push) begin mq.push_back(d); m_beats++; end
      if (drop) begin m_ovf = 1'b1; m_drops++; end
      else if (clr) m_ovf = 1'b0;
      @(negedge clk);
      check_all(tag);
   endtask

   task automatic do_reset();
      bus.proxy_valid = 1'b0;
      bus.proxy_data  = '0;
      bus.out_ready   = 1'b0;
      clr_overflow    = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      model_clear();
   endtask

   initial begin
      bus.proxy_valid = 1'b0;
      bus.proxy_data  = '0;
      bus.out_ready   = 1'b0;
      model_clear();

      // 1: idle after reset
      do_reset();
      check_all("rst");
      for (int i = 0; i < 10; i++) cyc("idle", 1'b0, 8'h00, 1'b1, 1'b0);

      // 2: streaming with consumer always ready
      cyc("t2a", 1'b1, 8'h11, 1'b1, 1'b0);
      chk("t2.d0", 32'(bus.out_data), 32'h11);
      cyc("t2b", 1'b1, 8'h22, 1'b1, 1'b0);
      chk("t2.d1", 32'(bus.out_data), 32'h22);
      cyc("t2c", 1'b1, 8'h33, 1'b1, 1'b0);
      chk("t2.d2", 32'(bus.out_data), 32'h33);
      chk("t2.cnt", 32'(fifo_count), 32'd1);
      cyc("t2d", 1'b0, 8'h00, 1'b1, 1'b0);

      // 3: overfill with consumer stalled, then drain
      do_reset();
      for (int i = 1; i <= 6; i++) cyc("t3f", 1'b1, 8'(i), 1'b0, 1'b0);
      chk("t3.cnt", 32'(fifo_count), 32'd4);
      chk("t3.ovf", 32'(overflow), 32'd1);
      chk("t3.drop", 32'(drop_cnt), stat_exp(2));
      for (int i = 1; i <= 4; i++) begin
         chk("t3.drain", 32'(bus.out_data), 32'(i));
         cyc("t3d", 1'b0, 8'h00, 1'b1, 1'b0);
      end

      // 4: full with simultaneous pop and push
      for (int i = 0; i < 4; i++) cyc("t4f", 1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0);
      cyc("t4s", 1'b1, 8'h5A, 1'b1, 1'b0);
      chk("t4.cnt", 32'(fifo_count), 32'd4);
      for (int i = 0; i < 3; i++) cyc("t4d", 1'b0, 8'h00, 1'b1, 1'b0);
      chk("t4.4th", 32'(bus.out_data), 32'h5A);
      cyc("t4e", 1'b0, 8'h00, 1'b1, 1'b0);

      // 5: clear colliding with a drop, then a clean clear
      do_reset();
      for (int i = 0; i < 4; i++) cyc("t5f", 1'b1, 8'(i), 1'b0, 1'b0);
      cyc("t5a", 1'b1, 8'hEE, 1'b0, 1'b1);
      chk("t5.set_wins", 32'(overflow), 32'd1);
      cyc("t5b", 1'b0, 8'h00, 1'b0, 1'b1);
      chk("t5.cleared", 32'(overflow), 32'd0);

      // 6: reset mid-burst
      do_reset();
      for (int i = 0; i < 3; i++) cyc("t6f", 1'b1, 8'h60 + 8'(i), 1'b0, 1'b0);
      bus.proxy_valid = 1'b1;
      bus.proxy_data  = 8'h99;
      rst_n = 1'b0;
      #1;
      chk("t6.valid", 32'(bus.out_valid), 32'd0);
      chk("t6.cnt", 32'(fifo_count), 32'd0);
      @(negedge clk);
      chk("t6.hold", 32'(bus.out_valid), 32'd0);
      rst_n = 1'b1;
      model_clear();
      cyc("t6n", 1'b1, 8'h77, 1'b0, 1'b0);
      chk("t6.head", 32'(bus.out_data), 32'h77);

      // random traffic
      do_reset();
      for (int i = 0; i < 600; i++) begin
         cyc("rnd",
             1'($urandom_range(0, 99) < 70),
             8'($urandom),
             1'($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 30 : 80)),
             1'($urandom_range(0, 99) < 10));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
